mdio_master: RTL and testbench

CSR-attached IEEE 802.3 Clause 22 MDIO management master. It generates MDC and serialises complete 64-bit read/write management frames to the Ethernet PHY, so software does not bit-bang MDIO. It sits downstream of the CSR bridge, alongside the GPIO, UART, sysctl and MAC CSR slaves, and ORs its `csr_do` into the bridge read mux. Its pins drive the PHY management interface at the top level.

---
 rtl/mdio_master.sv | 170 +++++++++++++++++
 tb/tb_mdio_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO master on the CSR bus.
// Ports: sys_clk/sys_rst, csr_a/we/di/do, irq, phy_mdc, phy_mdio_o/oe/i.
module mdio_master #(
    parameter logic [3:0]  csr_addr = 4'h0,
    parameter int unsigned clk_div  = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    output logic        phy_mdc,
    output logic        phy_mdio_o,
    output logic        phy_mdio_oe,
    input  logic        phy_mdio_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_TA, S_DATA
    } state_t;

    localparam logic [15:0] TICK_MAX = 16'(clk_div - 1);

    state_t      state, state_n;
    logic [5:0]  bit_cnt, bit_n;
    logic [15:0] tick, tick_n;
    logic        mdc_n, mdo_n, oe_n;
    logic [31:0] shreg, sh_n;
    logic [15:0] rsh, rsh_n;
    logic        wr_q, wr_n;
    logic        fin;
    logic        mdi_s1, mdi_s2;
    logic [15:0] wdata, rdata;
    logic        done, irq_en, busy;
    logic        sel, cmd_go;
    logic        unused_bits;

    assign sel    = csr_a[13:10] == csr_addr;
    assign busy   = state != S_IDLE;
    assign cmd_go = sel && csr_we && csr_a[1:0] == 2'd0 && !busy;
    assign unused_bits = ^{csr_di[31:16], csr_a[9:2]};

    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        tick_n  = tick;
        mdc_n   = phy_mdc;
        mdo_n   = phy_mdio_o;
        oe_n    = phy_mdio_oe;
        sh_n    = shreg;
        rsh_n   = rsh;
        wr_n    = wr_q;
        fin     = 1'b0;
        if (state == S_IDLE) begin
            mdc_n = 1'b0;
            mdo_n = 1'b1;
            oe_n  = 1'b0;
            if (cmd_go) begin
                // Preamble is implicit; shreg holds ST..DATA.
                state_n = S_PRE;
                bit_n   = 6'd0;
                tick_n  = 16'd0;
                oe_n    = 1'b1;
                wr_n    = csr_di[10];
                sh_n    = {2'b01,
                           csr_di[10] ? 2'b01 : 2'b10,
                           csr_di[9:5], csr_di[4:0],
                           csr_di[10] ? 2'b10 : 2'b11,
                           wdata};
            end
        end else begin
            // Sample on the first high cycle of each data bit.
            if (state == S_DATA && phy_mdc && tick == 16'd0)
                rsh_n = {rsh[14:0], mdi_s2};
            if (tick != TICK_MAX) begin
                tick_n = tick + 16'd1;
            end else begin
                tick_n = 16'd0;
                mdc_n  = ~phy_mdc;
                if (phy_mdc) begin
                    if (bit_cnt == 6'd63) begin
                        state_n = S_IDLE;
                        bit_n   = 6'd0;
                        mdo_n   = 1'b1;
                        oe_n    = 1'b0;
                        fin     = 1'b1;
                    end else begin
                        bit_n = bit_cnt + 6'd1;
                        unique case (1'b1)
                            bit_n == 6'd32: state_n = S_HDR;
                            bit_n == 6'd46: state_n = S_TA;
                            bit_n == 6'd48: state_n = S_DATA;
                            default: ;
                        endcase
                        if (bit_n[5]) begin
                            mdo_n = shreg[31];
                            sh_n  = {shreg[30:0], 1'b0};
                        end else begin
                            mdo_n = 1'b1;
                        end
                        oe_n = (bit_n < 6'd46) || wr_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            bit_cnt     <= 6'd0;
            tick        <= 16'd0;
            phy_mdc     <= 1'b0;
            phy_mdio_o  <= 1'b1;
            phy_mdio_oe <= 1'b0;
            shreg       <= 32'd0;
            rsh         <= 16'd0;
            wr_q        <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_n;
            tick        <= tick_n;
            phy_mdc     <= mdc_n;
            phy_mdio_o  <= mdo_n;
            phy_mdio_oe <= oe_n;
            shreg       <= sh_n;
            rsh         <= rsh_n;
            wr_q        <= wr_n;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wdata  <= 16'd0;
            rdata  <= 16'd0;
            done   <= 1'b0;
            irq_en <= 1'b0;
            irq    <= 1'b0;
            csr_do <= 32'd0;
            mdi_s1 <= 1'b1;
            mdi_s2 <= 1'b1;
        end else begin
            mdi_s1 <= phy_mdio_i;
            mdi_s2 <= mdi_s1;
            irq    <= done & irq_en;
            if (sel && csr_we && csr_a[1:0] == 2'd1)
                wdata <= csr_di[15:0];
            if (sel && csr_we && csr_a[1:0] == 2'd2) begin
                irq_en <= csr_di[2];
                if (csr_di[1])
                    done <= 1'b0;
            end
            // Frame end overrides a same-cycle clear.
            if (fin)
                done <= 1'b1;
            if (fin && !wr_q)
                rdata <= rsh_n;
            csr_do <= 32'd0;
            if (sel) begin
                unique case (csr_a[1:0])
                    2'd0: csr_do <= 32'd0;
                    2'd1: csr_do <= {16'd0, wdata};
                    2'd2: csr_do <= {29'd0, irq_en, done, busy};
                    2'd3: csr_do <= {16'd0, rdata};
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed vectors for mdio_master.
// Three instances (MDC half-periods 10, 3, 1) on CSR pages 0..2.
module tb_mdio_master;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [13:0] csr_a   = 14'd0;
    logic        csr_we  = 1'b0;
    logic [31:0] csr_di  = 32'd0;
    logic [31:0] do0, do1, do2;
    logic        irq0, irq1, irq2;
    logic        mdc0, mdc1, mdc2;
    logic        mo0, mo1, mo2;
    logic        oe0, oe1, oe2;
    logic        mi0 = 1'b1, mi1 = 1'b1, mi2 = 1'b1;
    logic [31:0] csr_do;

    int n_chk = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    mdio_master #(.csr_addr(4'h0), .clk_div(10)) u0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(do0), .irq(irq0),
        .phy_mdc(mdc0), .phy_mdio_o(mo0),
        .phy_mdio_oe(oe0), .phy_mdio_i(mi0)
    );
    mdio_master #(.csr_addr(4'h1), .clk_div(3)) u1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(do1), .irq(irq1),
        .phy_mdc(mdc1), .phy_mdio_o(mo1),
        .phy_mdio_oe(oe1), .phy_mdio_i(mi1)
    );
    mdio_master #(.csr_addr(4'h2), .clk_div(1)) u2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(do2), .irq(irq2),
        .phy_mdc(mdc2), .phy_mdio_o(mo2),
        .phy_mdio_oe(oe2), .phy_mdio_i(mi2)
    );

    assign csr_do = do0 | do1 | do2;

    typedef struct packed {
        int          page;
        int          div;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] phy_data;
        logic        irq_en;
        logic [13:0] exp_hdr;
        logic [15:0] exp_rdata;
        int          exp_len;
        logic        guard;
        logic        race;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pins(input int p);
        case (p)
            0: return {irq0, mdc0, mo0, oe0};
            1: return {irq1, mdc1, mo1, oe1};
            default: return {irq2, mdc2, mo2, oe2};
        endcase
    endfunction

    task automatic set_mi(input int p, input logic v);
        case (p)
            0: mi0 = v;
            1: mi1 = v;
            default: mi2 = v;
        endcase
    endtask

    function automatic logic [13:0] addr(input int p, input int idx);
        return {4'(p), 8'h00, 2'(idx)};
    endfunction

    task automatic csr_wr(input int p, input int idx,
                          input logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = addr(p, idx);
        csr_we = 1'b1;
        csr_di = d;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input int p, input int idx,
                          output logic [31:0] v);
        @(negedge sys_clk);
        csr_a  = addr(p, idx);
        csr_we = 1'b0;
        @(negedge sys_clk);
        v = csr_do;
    endtask

    task automatic run_frame(input vec_t v, input int abort_bit);
        logic [63:0] cap_o, cap_oe;
        logic [3:0]  pn;
        logic [31:0] rd;
        logic        prev, rd_st, aborted;
        int          nrise, first_rise, done_t, b;
        cap_o = '0;
        cap_oe = '0;
        prev = 1'b0;
        rd_st = 1'b0;
        aborted = 1'b0;
        nrise = 0;
        first_rise = 0;
        done_t = 0;
        set_mi(v.page, 1'b1);
        csr_wr(v.page, 1, {16'd0, v.wdata});
        csr_wr(v.page, 2, {29'd0, v.irq_en, 2'b10});
        @(negedge sys_clk);
        csr_a  = addr(v.page, 0);
        csr_we = 1'b1;
        csr_di = {21'd0, v.wr, v.phy, v.regad};
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_a  = addr(v.page, 2);
        for (int t = 1; t <= v.exp_len + 40; t++) begin
            pn = pins(v.page);
            if (pn[2] && !prev) begin
                if (nrise < 64) begin
                    cap_o[63 - nrise]  = pn[1];
                    cap_oe[63 - nrise] = pn[0];
                end
                if (first_rise == 0)
                    first_rise = t;
                b = nrise + 1;
                if (!v.wr && b >= 48 && b <= 63)
                    set_mi(v.page, v.phy_data[63 - b]);
                else if (!v.wr && b == 47)
                    set_mi(v.page, 1'b0);
                else
                    set_mi(v.page, 1'b1);
                nrise++;
                if (abort_bit >= 0 && nrise == abort_bit + 1) begin
                    sys_rst = 1'b1;
                    aborted = 1'b1;
                    break;
                end
            end
            prev = pn[2];
            if (t == 2 && rd_st)
                chk("busy_after_cmd", 64'(csr_do[0]), 64'd1);
            if (t >= 2 && rd_st && csr_do[1]) begin
                done_t = t - 1;
                chk("idle_pins_at_done", 64'(pn[2:0]), 64'b010);
                break;
            end
            if (v.guard && t == 300) begin
                csr_a  = addr(v.page, 0);
                csr_we = 1'b1;
                csr_di = {21'd0, ~v.wr, 5'h1F, 5'h1F};
            end
            if (v.guard && t == 301) begin
                csr_a  = addr(v.page, 1);
                csr_di = 32'h0000_FFFF;
            end
            if (v.guard && t == 302) begin
                csr_we = 1'b0;
                csr_a  = addr(v.page, 2);
            end
            if (v.race && t == v.exp_len - 1) begin
                csr_we = 1'b1;
                csr_di = {29'd0, v.irq_en, 2'b10};
            end
            if (v.race && t == v.exp_len)
                csr_we = 1'b0;
            rd_st = csr_a[1:0] == 2'd2;
            @(negedge sys_clk);
        end
        csr_we = 1'b0;
        if (abort_bit >= 0) begin
            chk("abort_reached", 64'(aborted), 64'd1);
        end else begin
            chk("done_cycle", 64'(done_t), 64'(v.exp_len));
            chk("first_rise", 64'(first_rise), 64'(v.div + 1));
            chk("rise_count", 64'(nrise), 64'd64);
            chk("preamble", cap_o[63:32], 64'hFFFF_FFFF);
            chk("header", 64'(cap_o[31:18]), 64'(v.exp_hdr));
            if (v.wr) begin
                chk("ta_data", 64'(cap_o[17:0]),
                    64'({2'b10, v.wdata}));
                chk("oe_write", cap_oe, {64{1'b1}});
            end else begin
                chk("oe_read", cap_oe, {{46{1'b1}}, 18'd0});
                csr_rd(v.page, 3, rd);
                chk("rdata", 64'(rd), 64'(v.exp_rdata));
            end
            csr_rd(v.page, 2, rd);
            chk("status_end", 64'(rd),
                64'({v.irq_en, 2'b10}));
            pn = pins(v.page);
            chk("irq_end", 64'(pn[3]), 64'(v.irq_en));
            if (v.guard) begin
                csr_rd(v.page, 1, rd);
                chk("wdata_late_write", 64'(rd), 64'h FFFF);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        tbl[0] = '{0, 10, 5'd1, 5'd0, 1'b1, 16'h1140, 16'h0000,
                   1'b0, 14'h1420, 16'h0000, 1281, 1'b0, 1'b0};
        tbl[1] = '{0, 10, 5'd1, 5'd2, 1'b0, 16'h0000, 16'h796D,
                   1'b1, 14'h1822, 16'h796D, 1281, 1'b0, 1'b0};
        tbl[2] = '{0, 10, 5'd3, 5'd4, 1'b1, 16'h0F0F, 16'h0000,
                   1'b0, 14'h1464, 16'h0000, 1281, 1'b1, 1'b0};
        tbl[3] = '{0, 10, 5'd1, 5'd2, 1'b0, 16'h0000, 16'hC3A5,
                   1'b1, 14'h1822, 16'hC3A5, 1281, 1'b0, 1'b1};
        tbl[4] = '{1, 3, 5'h1F, 5'h1F, 1'b1, 16'hA5C3, 16'h0000,
                   1'b1, 14'h17FF, 16'h0000, 385, 1'b0, 1'b0};
        tbl[5] = '{2, 1, 5'h12, 5'h05, 1'b0, 16'h0000, 16'h8001,
                   1'b0, 14'h1A45, 16'h8001, 129, 1'b0, 1'b0};

        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("rst_mdc", 64'(mdc0), 64'd0);
        chk("rst_oe", 64'(oe0), 64'd0);
        chk("rst_mdio_o", 64'(mo0), 64'd1);
        chk("rst_irq", 64'(irq0), 64'd0);
        for (int i = 0; i < 4; i++) begin
            csr_rd(0, i, rd);
            chk("rst_reg", 64'(rd), 64'd0);
        end

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i], -1);

        csr_wr(0, 2, 32'h6);
        csr_rd(0, 2, rd);
        chk("done_cleared", 64'(rd), 64'h4);
        repeat (2) @(negedge sys_clk);
        chk("irq_cleared", 64'(irq0), 64'd0);

        run_frame(tbl[0], 40);
        @(negedge sys_clk);
        chk("abort_mdc", 64'(mdc0), 64'd0);
        chk("abort_oe", 64'(oe0), 64'd0);
        chk("abort_mdio_o", 64'(mo0), 64'd1);
        chk("abort_csr_do", 64'(csr_do), 64'd0);
        sys_rst = 1'b0;
        csr_rd(0, 2, rd);
        chk("abort_status", 64'(rd), 64'd0);
        csr_rd(0, 1, rd);
        chk("abort_wdata", 64'(rd), 64'd0);
        run_frame(tbl[4], -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
